// File: rtl/bus_led_defs.sv
// Shared colours and default geometry for the bus LED renderer.
// Optional feature macro: BUS_LED_CHANGE_HILITE_EN (see bus_led_renderer.sv).
package bus_led_defs;

  // Coordinate width delivered by the sync generator.
  localparam int unsigned COORD_W = 11;
  // Row/column index width; covers 8 columns and up to 11 rows plus the
  // saturated "past the end" value.
  localparam int unsigned IDX_W = 4;

  localparam int unsigned LEDS_PER_ROW = 8;

  // RGB 8:8:8 colours.
  localparam logic [23:0] COL_BG  = 24'h000000;
  localparam logic [23:0] COL_ON  = 24'hFF0000;
  localparam logic [23:0] COL_OFF = 24'h300000;
  localparam logic [23:0] COL_CHG = 24'hFFFF00;

  // Default geometry.
  localparam int unsigned DEF_NUM_REGS  = 8;
  localparam int unsigned DEF_ORIGIN_X  = 160;
  localparam int unsigned DEF_ORIGIN_Y  = 40;
  localparam int unsigned DEF_LED_SIZE  = 32;
  localparam int unsigned DEF_LED_GAP   = 8;
  localparam int unsigned DEF_H_ACTIVE  = 640;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_SNAP_LINE = 480;

endpackage

// File: rtl/bus_led_axis_tracker.sv
// Divider-free position tracker for one screen axis.
// Follows a coordinate that normally steps by one, and reports which LED
// cell it is in (index), whether it is inside the lit square (inside_led)
// and whether the index is meaningful (valid). The reload point arms the
// tracker; any jump other than +1 or "unchanged" disarms it until the next
// reload, so a line or frame wrap never leaks into column/row 0.
module bus_led_axis_tracker
  import bus_led_defs::*;
(
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] coord,
  input  logic               reload_en,
  input  logic [COORD_W-1:0] origin,
  input  logic [COORD_W-1:0] pitch,
  input  logic [COORD_W-1:0] size,
  input  logic [IDX_W-1:0]   limit,
  output logic [IDX_W-1:0]   index,
  output logic               inside_led,
  output logic               valid
);

  logic [COORD_W-1:0] prev_coord;
  logic [COORD_W-1:0] off_q;
  logic [COORD_W-1:0] off_next;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_next;
  logic               armed_q;
  logic               armed_next;
  logic               step;
  logic               hold;

  // Position of the coordinate presented this cycle, derived from the
  // position of the previous one.
  always_comb begin
    step       = (coord == prev_coord + COORD_W'(1));
    hold       = (coord == prev_coord);
    off_next   = off_q;
    idx_next   = idx_q;
    armed_next = armed_q;
    if (reload_en && (coord == origin)) begin
      off_next   = '0;
      idx_next   = '0;
      armed_next = 1'b1;
    end else if (step) begin
      // Saturate at limit: the index parks there instead of wrapping.
      if (armed_q && (idx_q != limit)) begin
        if (off_q == pitch - COORD_W'(1)) begin
          off_next = '0;
          idx_next = idx_q + IDX_W'(1);
        end else begin
          off_next = off_q + COORD_W'(1);
        end
      end
    end else if (!hold) begin
      armed_next = 1'b0;
    end
  end

  // Outputs describe the coordinate presented this cycle.
  always_comb begin
    index      = idx_next;
    inside_led = (off_next < size);
    valid      = armed_next && (idx_next < limit);
  end

  // Tracker state register.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      prev_coord <= '0;
      off_q      <= '0;
      idx_q      <= '0;
      armed_q    <= 1'b0;
    end else begin
      prev_coord <= coord;
      off_q      <= off_next;
      idx_q      <= idx_next;
      armed_q    <= armed_next;
    end
  end

endmodule

// File: rtl/bus_led_renderer.sv
// Renders NUM_REGS 8-bit values as rows of eight LED squares (bit 7 left).
// Pixel for (next_pixel_h, next_pixel_v) appears one vga_clk later.
// Values are snapshotted into a shadow copy once per frame on SNAP_LINE.
// Optional macro BUS_LED_CHANGE_HILITE_EN: keep the previous snapshot and
// paint LEDs whose bit changed between the last two snapshots yellow.
module bus_led_renderer
  import bus_led_defs::*;
#(
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned ORIGIN_X  = DEF_ORIGIN_X,
  parameter int unsigned ORIGIN_Y  = DEF_ORIGIN_Y,
  parameter int unsigned LED_SIZE  = DEF_LED_SIZE,
  parameter int unsigned LED_GAP   = DEF_LED_GAP,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned SNAP_LINE = DEF_SNAP_LINE
)(
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic [10:0]           next_pixel_h,
  input  logic [10:0]           next_pixel_v,
  input  logic [NUM_REGS*8-1:0] reg_values,
  output logic [23:0]           pixel,
  output logic                  frame_tick
);

  localparam logic [COORD_W-1:0] ORG_X_C  = COORD_W'(ORIGIN_X);
  localparam logic [COORD_W-1:0] ORG_Y_C  = COORD_W'(ORIGIN_Y);
  localparam logic [COORD_W-1:0] PITCH_C  = COORD_W'(LED_SIZE + LED_GAP);
  localparam logic [COORD_W-1:0] SIZE_C   = COORD_W'(LED_SIZE);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] SNAP_C   = COORD_W'(SNAP_LINE);
  localparam logic [IDX_W-1:0]   COLS_C   = IDX_W'(LEDS_PER_ROW);
  localparam logic [IDX_W-1:0]   ROWS_C   = IDX_W'(NUM_REGS);

  logic [NUM_REGS*8-1:0] shadow;
  logic [IDX_W-1:0]      col_idx;
  logic [IDX_W-1:0]      row_idx;
  logic                  col_in_led;
  logic                  row_in_led;
  logic                  col_valid;
  logic                  row_valid;
  logic                  snap;
  logic                  y_reload_en;
  logic                  in_led;
  logic [7:0]            row_bits;
  logic [7:0]            col_mask;
  logic                  led_on;
  logic [23:0]           pixel_next;

`ifdef BUS_LED_CHANGE_HILITE_EN
  logic [NUM_REGS*8-1:0] prev;
  logic [7:0]            chg_bits;
  logic                  led_chg;
`endif

  bus_led_axis_tracker u_x_track (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .coord      (next_pixel_h),
    .reload_en  (1'b1),
    .origin     (ORG_X_C),
    .pitch      (PITCH_C),
    .size       (SIZE_C),
    .limit      (COLS_C),
    .index      (col_idx),
    .inside_led (col_in_led),
    .valid      (col_valid)
  );

  bus_led_axis_tracker u_y_track (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .coord      (next_pixel_v),
    .reload_en  (y_reload_en),
    .origin     (ORG_Y_C),
    .pitch      (PITCH_C),
    .size       (SIZE_C),
    .limit      (ROWS_C),
    .index      (row_idx),
    .inside_led (row_in_led),
    .valid      (row_valid)
  );

  // Frame-level strobes decoded from the incoming coordinate.
  always_comb begin
    y_reload_en = (next_pixel_h == '0);
    snap        = (next_pixel_v == SNAP_C) && (next_pixel_h == '0);
  end

  // Snapshot of the displayed values, taken once per frame in blanking.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else if (snap) begin
      shadow <= reg_values;
    end
  end

`ifdef BUS_LED_CHANGE_HILITE_EN
  // Previous snapshot, kept for change highlighting.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      prev <= '0;
    end else if (snap) begin
      prev <= shadow;
    end
  end
`endif

  // LED bit lookup via shifts so no multiplier/mux tree is inferred from
  // the row index; out-of-range indices shift to zero and are masked anyway.
  always_comb begin
    row_bits = 8'(shadow >> {row_idx, 3'b000});
    col_mask = 8'h80 >> col_idx;
    led_on   = |(row_bits & col_mask);
`ifdef BUS_LED_CHANGE_HILITE_EN
    chg_bits = 8'((shadow ^ prev) >> {row_idx, 3'b000});
    led_chg  = |(chg_bits & col_mask);
`endif
  end

  // Colour of the pixel presented this cycle.
  always_comb begin
    in_led = col_valid && row_valid && col_in_led && row_in_led &&
             (next_pixel_h < H_ACT_C) && (next_pixel_v < V_ACT_C);
    pixel_next = COL_BG;
    if (in_led) begin
`ifdef BUS_LED_CHANGE_HILITE_EN
      if (led_chg) begin
        pixel_next = COL_CHG;
      end else begin
        pixel_next = led_on ? COL_ON : COL_OFF;
      end
`else
      pixel_next = led_on ? COL_ON : COL_OFF;
`endif
    end
  end

  // Registered outputs.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      pixel      <= '0;
      frame_tick <= 1'b0;
    end else begin
      pixel      <= pixel_next;
      frame_tick <= snap;
    end
  end

endmodule

// File: tb/tb_bus_led_renderer.sv
// Scoreboard bench for bus_led_renderer. The stimulus is a compressed raster:
// every line gets h=0, and selected lines are scanned over h=160..639.
module tb_bus_led_renderer;

  localparam int NR = 8;

  localparam logic [NR*8-1:0] P_FF = {NR{8'hFF}};
  localparam logic [NR*8-1:0] P_A  = {8'h5A, 8'hC3, 8'h00, 8'hFF, 8'h3C, 8'h7E, 8'h18, 8'h81};
  localparam logic [NR*8-1:0] P_B  = {8'hA5, 8'h01, 8'h80, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h7E};
  localparam logic [NR*8-1:0] P_C  = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00};
  localparam logic [NR*8-1:0] P_D  = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h01};

  logic            vga_clk = 1'b0;
  logic            reset   = 1'b1;
  logic [10:0]     h = '0;
  logic [10:0]     v = '0;
  logic [NR*8-1:0] regs = '0;
  logic [23:0]     pixel;
  logic            frame_tick;

  int checks   = 0;
  int failures = 0;
  int ticks    = 0;
  logic drv_busy = 1'b0;

  typedef struct {
    logic [23:0] pix;
    logic        tick;
    int          h;
    int          v;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_shadow [NR];
  logic [7:0] m_prev   [NR];

  always #5 vga_clk = ~vga_clk;

  bus_led_renderer #(.NUM_REGS(NR)) dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .next_pixel_h (h),
    .next_pixel_v (v),
    .reg_values   (regs),
    .pixel        (pixel),
    .frame_tick   (frame_tick)
  );

  function automatic logic [23:0] expect_pix(input int x, input int y);
    int cx, cy, ox, oy;
    logic [7:0] row;
    logic [7:0] old;
    if (x >= 640 || y >= 480 || x < 160 || y < 40) return 24'h000000;
    cx = (x - 160) / 40;
    ox = (x - 160) % 40;
    cy = (y - 40) / 40;
    oy = (y - 40) % 40;
    if (cx >= 8 || cy >= NR || ox >= 32 || oy >= 32) return 24'h000000;
    row = m_shadow[cy];
    old = m_prev[cy];
`ifdef BUS_LED_CHANGE_HILITE_EN
    if (1'(row >> (7 - cx)) != 1'(old >> (7 - cx))) return 24'hFFFF00;
`endif
    return 1'(row >> (7 - cx)) ? 24'hFF0000 : 24'h300000;
  endfunction

  function automatic bit is_scan(input int vv);
    return vv == 40 || vv == 41 || vv == 72 || vv == 150 || vv == 200 ||
           vv == 359 || vv == 360 || vv == 479;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_shadow[r] = '0;
      m_prev[r]   = '0;
    end
  endtask

  // Drive one coordinate and record what the renderer must answer.
  task automatic drive(input int hh, input int vv);
    exp_t e;
    @(negedge vga_clk);
    h      = 11'(hh);
    v      = 11'(vv);
    e.pix  = expect_pix(hh, vv);
    e.tick = (hh == 0 && vv == 480);
    e.h    = hh;
    e.v    = vv;
    sb.push_back(e);
    if (e.tick) begin
      for (int r = 0; r < NR; r++) begin
        m_prev[r]   = m_shadow[r];
        m_shadow[r] = 8'(regs >> (r * 8));
      end
    end
  endtask

  task automatic run_frame(input int v0, input int v1, input int chg_v,
                           input logic [NR*8-1:0] chg_val);
    for (int vv = v0; vv <= v1; vv++) begin
      if (vv == chg_v) regs = chg_val;
      drive(0, vv);
      if (is_scan(vv)) begin
        for (int hh = 160; hh < 640; hh++) drive(hh, vv);
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pixel !== 24'h0) begin
      failures++;
      $display("FAIL reset_pixel: got %h, expected %h", pixel, 24'h0);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick: got %b, expected 0", frame_tick);
    end
    model_reset();
    regs = P_FF;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b1;
    ticks = 0;
    drv_busy = 1'b1;
    fork
      begin
        run_frame(400, 524, -1, P_FF);
        drv_busy = 1'b0;
      end
      begin
        while (drv_busy || sb.size() != 0) begin
          @(posedge vga_clk); #1;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (pixel !== e.pix) begin
              failures++;
              $display("FAIL reset_frame_pixel (%0d,%0d): got %h, expected %h", e.h, e.v, pixel, e.pix);
            end
            checks++;
            if (frame_tick !== e.tick) begin
              failures++;
              $display("FAIL reset_frame_tick (%0d,%0d): got %b, expected %b", e.h, e.v, frame_tick, e.tick);
            end
            if (frame_tick === 1'b1) ticks++;
          end
        end
      end
    join
    checks++;
    if (ticks != 1) begin
      failures++;
      $display("FAIL tick_count: got %0d, expected 1", ticks);
    end
  endtask

  task automatic test_pattern();
    exp_t e;
    regs = P_A;
    drv_busy = 1'b1;
    fork
      begin
        run_frame(0, 524, -1, P_A);
        run_frame(0, 524, -1, P_A);
        drv_busy = 1'b0;
      end
      begin
        while (drv_busy || sb.size() != 0) begin
          @(posedge vga_clk); #1;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (pixel !== e.pix) begin
              failures++;
              $display("FAIL pattern_pixel (%0d,%0d): got %h, expected %h", e.h, e.v, pixel, e.pix);
            end
            checks++;
            if (frame_tick !== e.tick) begin
              failures++;
              $display("FAIL pattern_tick (%0d,%0d): got %b, expected %b", e.h, e.v, frame_tick, e.tick);
            end
          end
        end
      end
    join
  endtask

  task automatic test_midframe_change();
    exp_t e;
    drv_busy = 1'b1;
    fork
      begin
        run_frame(0, 524, 100, P_B);
        drv_busy = 1'b0;
      end
      begin
        while (drv_busy || sb.size() != 0) begin
          @(posedge vga_clk); #1;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (pixel !== e.pix) begin
              failures++;
              $display("FAIL midframe_pixel (%0d,%0d): got %h, expected %h", e.h, e.v, pixel, e.pix);
            end
            checks++;
            if (frame_tick !== e.tick) begin
              failures++;
              $display("FAIL midframe_tick (%0d,%0d): got %b, expected %b", e.h, e.v, frame_tick, e.tick);
            end
          end
        end
      end
    join
  endtask

  task automatic test_boundary();
    exp_t e;
    drv_busy = 1'b1;
    fork
      begin
        run_frame(0, 524, -1, P_B);
        drv_busy = 1'b0;
      end
      begin
        while (drv_busy || sb.size() != 0) begin
          @(posedge vga_clk); #1;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (pixel !== e.pix) begin
              failures++;
              $display("FAIL boundary_pixel (%0d,%0d): got %h, expected %h", e.h, e.v, pixel, e.pix);
            end
            checks++;
            if (frame_tick !== e.tick) begin
              failures++;
              $display("FAIL boundary_tick (%0d,%0d): got %b, expected %b", e.h, e.v, frame_tick, e.tick);
            end
          end
        end
      end
    join
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    regs = P_C;
    drv_busy = 1'b1;
    fork
      begin
        run_frame(0, 199, -1, P_C);
        drive(0, 200);
        for (int hh = 160; hh <= 300; hh++) drive(hh, 200);
        drv_busy = 1'b0;
      end
      begin
        while (drv_busy || sb.size() != 0) begin
          @(posedge vga_clk); #1;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (pixel !== e.pix) begin
              failures++;
              $display("FAIL pre_reset_pixel (%0d,%0d): got %h, expected %h", e.h, e.v, pixel, e.pix);
            end
          end
        end
      end
    join
    // Assert reset between edges; the output must clear without a clock.
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pixel !== 24'h0) begin
      failures++;
      $display("FAIL async_reset_pixel: got %h, expected %h", pixel, 24'h0);
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk); #1;
      checks++;
      if (pixel !== 24'h0 || frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL held_reset cycle %0d: got %h/%b, expected 000000/0", i, pixel, frame_tick);
      end
    end
    @(negedge vga_clk);
    reset = 1'b1;
    drv_busy = 1'b1;
    fork
      begin
        run_frame(0, 524, -1, P_C);
        drv_busy = 1'b0;
      end
      begin
        while (drv_busy || sb.size() != 0) begin
          @(posedge vga_clk); #1;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (pixel !== e.pix) begin
              failures++;
              $display("FAIL post_reset_pixel (%0d,%0d): got %h, expected %h", e.h, e.v, pixel, e.pix);
            end
            checks++;
            if (frame_tick !== e.tick) begin
              failures++;
              $display("FAIL post_reset_tick (%0d,%0d): got %b, expected %b", e.h, e.v, frame_tick, e.tick);
            end
          end
        end
      end
    join
  endtask

  task automatic test_hilite();
    exp_t e;
    regs = P_D;
    drv_busy = 1'b1;
    fork
      begin
        for (int f = 0; f < 3; f++) run_frame(0, 524, -1, P_D);
        drv_busy = 1'b0;
      end
      begin
        while (drv_busy || sb.size() != 0) begin
          @(posedge vga_clk); #1;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (pixel !== e.pix) begin
              failures++;
              $display("FAIL hilite_pixel (%0d,%0d): got %h, expected %h", e.h, e.v, pixel, e.pix);
            end
            checks++;
            if (frame_tick !== e.tick) begin
              failures++;
              $display("FAIL hilite_tick (%0d,%0d): got %b, expected %b", e.h, e.v, frame_tick, e.tick);
            end
          end
        end
      end
    join
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pattern();
    test_midframe_change();
    test_boundary();
    test_reset_midframe();
    test_hilite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_led_renderer.md
Name: bus_led_renderer

Overview:
- Pixel source for the VGA controller. Draws NUM_REGS 8-bit computer registers/buses as rows of eight square "LEDs" (bit 7 leftmost).
- Consumes next_pixel_h/next_pixel_v from the sync generator and returns the 24-bit pixel one vga_clk later.
- Register values are snapshotted once per frame in vertical blanking, so a frame never tears.

Parameters:
- NUM_REGS, 8, number of 8-bit values displayed (one LED row each); 1..11.
- ORIGIN_X, 160, x of left edge of column 0.
- ORIGIN_Y, 40, y of top edge of row 0.
- LED_SIZE, 32, LED square side in pixels.
- LED_GAP, 8, background gap between LEDs. Pitch P = LED_SIZE+LED_GAP.
- H_ACTIVE, 640, visible width.
- V_ACTIVE, 480, visible height.
- SNAP_LINE, 480, line on which the snapshot is taken; must be >= V_ACTIVE.

Ports:
- vga_clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- next_pixel_h  in  11  x of the pixel to produce.
- next_pixel_v  in  11  y of the pixel to produce.
- reg_values  in  NUM_REGS*8  packed values; row r = reg_values[r*8+7:r*8].
- pixel  out  24  RGB 8:8:8, registered.
- frame_tick  out  1  one-cycle pulse on the snapshot cycle.

Behaviour:
- Reset (reset=0, async): pixel=0, frame_tick=0, shadow registers=0, all internal counters cleared. Release is synchronous to vga_clk.
- Latency: pixel at edge t+1 is the function of next_pixel_h/v sampled at edge t. Latency is exactly 1, with no bubbles.
- Snapshot:
  - Condition: next_pixel_v==SNAP_LINE and next_pixel_h==0.
  - On that edge, shadow <= reg_values and frame_tick <= 1; otherwise frame_tick <= 0.
  - Rendering uses shadow only, never reg_values directly.
- Geometry: no dividers/multipliers. Row/column and in-cell offset come from counters.
  - Horizontal counters reload when next_pixel_h==ORIGIN_X.
  - Vertical counters reload when next_pixel_v==ORIGIN_Y and next_pixel_h==0.
  - Counters advance on each increment of the respective coordinate.
  - Offset wraps at P-1, then the column/row index increments.
- Colour per pixel:
  - Outside H_ACTIVE/V_ACTIVE -> 24'h000000.
  - Column index >=8, row index >=NUM_REGS, x<ORIGIN_X or y<ORIGIN_Y -> background 24'h000000.
  - Offset >= LED_SIZE in either axis (gap) -> background.
  - Inside LED (row r, column c): bit b = shadow[r][7-c]. b=1 -> ON 24'hFF0000; b=0 -> OFF 24'h300000.
- Boundaries:
  - x = ORIGIN_X+8P-1 is gap.
  - x = ORIGIN_X+8P is background; counters saturate and do not wrap back into column 0.
  - A jump of next_pixel_h back to 0 (line wrap) re-arms the horizontal reload.
- Mid-frame reg_values changes: no visible effect until the next snapshot.
- Reset mid-frame: output is black until the next pixel after release. Shadow stays 0 until the next snapshot.

Optional Feature:
- Macro: BUS_LED_CHANGE_HILITE_EN.
- Defined:
  - A second shadow (prev) holds the previous snapshot. On each snapshot, prev <= shadow.
  - An LED whose bit differs between shadow and prev renders 24'hFFFF00 (yellow), for exactly one frame.
  - prev resets to 0.
- Undefined: no prev storage; colours exactly as above.

Decomposition:
- Shared include/package bus_led_defs:
  - Colour constants COL_BG, COL_ON, COL_OFF, COL_CHG.
  - Default geometry localparams.
- Sub-module bus_led_axis_tracker, instantiated twice (x and y):
  - Inputs: coordinate, origin, pitch, size, limit count.
  - Outputs: index, inside_led, valid.
  - Contains the reload/offset/index counter logic.

Test Plan:
- Reset, then run frame 0 with reg_values all 8'hFF -> every pixel is 24'h000000; frame_tick pulses once at v=480, h=0.
- reg_values[7:0]=8'h81, after one snapshot -> at (160,40) and (440,40) pixel=FF0000. At (200,40) pixel=300000. At (192,40) (gap) pixel=000000. Each one cycle after the coordinate is applied.
- Change reg_values mid-frame at line 100 -> pixels for rows below line 100 in the same frame still show the old value; the new value appears from the next frame.
- Row boundary, NUM_REGS=8 -> y=359 (row 7 gap) is background; y=360 (row index 8) is background. Out of range x=480 and x=639 give 000000.
- Assert reset for 3 cycles at (300,200) mid-frame -> pixel=0 asynchronously. After release, shadow=0, so LEDs show OFF colour until the next frame_tick.
- With BUS_LED_CHANGE_HILITE_EN: row 0 goes 8'h00 -> 8'h01 -> bit0 LED (x=440) is FFFF00 for one frame, then FF0000.
